// File: rtl/turn_signal_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : turn_signal_ctrl
//  Purpose  : Driver-side command generator for the tail-light sequencer.
//             Synchronises and debounces the stalk contacts and hazard
//             button, runs the comfort-tap / latched-hold / wheel-cancel
//             turn FSM, and keeps hazard as a toggle that overrides lt/rt.
//  Revision : 1.0 - initial release
// ============================================================================
module turn_signal_ctrl #(
  parameter int DB_CYCLES    = 4,
  parameter int TAP_MAX      = 16,
  parameter int SWEEP_CYCLES = 4,
  parameter int TAP_FLASHES  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stalk_l,
  input  logic stalk_r,
  input  logic haz_btn,
  input  logic cancel,
  output logic lt,
  output logic rt,
  output logic haz
);

  // Counter widths: $clog2 of the largest count, plus one bit of headroom.
  localparam int c_DB_W    = $clog2(DB_CYCLES) + 1;
  localparam int c_HOLD_W  = $clog2(TAP_MAX) + 1;
  localparam int c_FLASH_W = $clog2(TAP_FLASHES * SWEEP_CYCLES) + 1;

  localparam logic [c_DB_W-1:0]    c_DB_LAST    = c_DB_W'(DB_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(TAP_MAX - 1);
  localparam logic [c_FLASH_W-1:0] c_FLASH_LAST = c_FLASH_W'(TAP_FLASHES * SWEEP_CYCLES - 1);

  // Turn FSM encoding
  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_PRESS    = 3'd1;
  localparam logic [2:0] c_COMFORT  = 3'd2;
  localparam logic [2:0] c_HOLD     = 3'd3;
  localparam logic [2:0] c_WAIT_REL = 3'd4;

  localparam logic c_DIR_L = 1'b0;
  localparam logic c_DIR_R = 1'b1;

  // --------------------------------------------------------------------------
  // Input conditioning: bit 0 = left stalk, bit 1 = right stalk, bit 2 = hazard
  // --------------------------------------------------------------------------
  logic [2:0] w_raw;
  logic [2:0] w_db;

  assign w_raw = {haz_btn, stalk_r, stalk_l};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cond
    logic              r_sync1;
    logic              r_sync2;
    logic              r_db;
    logic [c_DB_W-1:0] r_cnt;

    // 2-FF synchroniser followed by a run-length debouncer; db only follows
    // sync after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_db    <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_db  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_db[gi] = r_db;
  end

  // --------------------------------------------------------------------------
  // Qualified stalk levels and edges
  // --------------------------------------------------------------------------
  logic w_db_l, w_db_r, w_db_h;
  logic w_l, w_r, w_fault;
  logic w_l_rise, w_r_rise, w_haz_rise;
  logic w_sel, w_opp;
  logic r_l_prev, r_r_prev, r_h_prev;

  assign w_db_l  = w_db[0];
  assign w_db_r  = w_db[1];
  assign w_db_h  = w_db[2];

  // Both stalks closed is a contact fault and counts as neither side.
  assign w_l     = w_db_l & ~w_db_r;
  assign w_r     = w_db_r & ~w_db_l;
  assign w_fault = w_db_l & w_db_r;

  assign w_l_rise   = w_l & ~r_l_prev;
  assign w_r_rise   = w_r & ~r_r_prev;
  assign w_haz_rise = w_db_h & ~r_h_prev;

  // Selected/opposite side relative to the currently latched direction
  logic r_dir;
  assign w_sel = (r_dir == c_DIR_R) ? w_r : w_l;
  assign w_opp = (r_dir == c_DIR_R) ? w_l : w_r;

  // Previous-cycle levels for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l_prev <= 1'b0;
      r_r_prev <= 1'b0;
      r_h_prev <= 1'b0;
    end else begin
      r_l_prev <= w_l;
      r_r_prev <= w_r;
      r_h_prev <= w_db_h;
    end
  end

  // --------------------------------------------------------------------------
  // Turn FSM
  // --------------------------------------------------------------------------
  logic [2:0]           r_state, w_state_nxt;
  logic                 w_dir_nxt;
  logic [c_HOLD_W-1:0]  r_hold_cnt, w_hold_nxt;
  logic [c_FLASH_W-1:0] r_flash_cnt, w_flash_nxt;
  logic                 r_lt, r_rt, r_haz;
  logic                 w_lt_nxt, w_rt_nxt, w_haz_nxt;

  // State, direction, counters and the registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_dir       <= c_DIR_L;
      r_hold_cnt  <= '0;
      r_flash_cnt <= '0;
      r_lt        <= 1'b0;
      r_rt        <= 1'b0;
      r_haz       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_flash_cnt <= w_flash_nxt;
      r_lt        <= w_lt_nxt;
      r_rt        <= w_rt_nxt;
      r_haz       <= w_haz_nxt;
    end
  end

  // Next-state logic; priority is fault > cancel > direction change > release/timeout
  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_hold_nxt  = r_hold_cnt;
    w_flash_nxt = r_flash_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_l_rise) begin
          w_state_nxt = c_PRESS;
          w_dir_nxt   = c_DIR_L;
          w_hold_nxt  = '0;
        end else if (w_r_rise) begin
          w_state_nxt = c_PRESS;
          w_dir_nxt   = c_DIR_R;
          w_hold_nxt  = '0;
        end
      end
      c_PRESS: begin
        if (r_hold_cnt != '1) w_hold_nxt = r_hold_cnt + 1'b1;
        if (w_fault) begin
          w_state_nxt = c_IDLE;
        end else if (cancel) begin
          w_state_nxt = c_WAIT_REL;
        end else if (w_opp) begin
          w_dir_nxt  = ~r_dir;
          w_hold_nxt = '0;
        end else if (!w_sel) begin
          // A release at the very last press cycle has already outlived a tap.
          if (r_hold_cnt < c_HOLD_LAST) begin
            w_state_nxt = c_COMFORT;
            w_flash_nxt = '0;
          end else begin
            w_state_nxt = c_IDLE;
          end
        end else if (r_hold_cnt == c_HOLD_LAST) begin
          w_state_nxt = c_HOLD;
        end
      end
      c_COMFORT: begin
        if (r_flash_cnt != '1) w_flash_nxt = r_flash_cnt + 1'b1;
        if (cancel) begin
          w_state_nxt = c_IDLE;
        end else if (w_l_rise) begin
          w_state_nxt = c_PRESS;
          w_dir_nxt   = c_DIR_L;
          w_hold_nxt  = '0;
        end else if (w_r_rise) begin
          w_state_nxt = c_PRESS;
          w_dir_nxt   = c_DIR_R;
          w_hold_nxt  = '0;
        end else if (r_flash_cnt == c_FLASH_LAST) begin
          w_state_nxt = c_IDLE;
        end
      end
      c_HOLD: begin
        if (w_fault) begin
          w_state_nxt = c_IDLE;
        end else if (cancel) begin
          w_state_nxt = c_WAIT_REL;
        end else if (!w_sel) begin
          w_state_nxt = c_IDLE;
        end
      end
      c_WAIT_REL: begin
        // Wait for the driver to let go so a wheel cancel cannot re-latch.
        if (!w_l && !w_r) w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // Output decode from next state; hazard masks the turn requests
  always_comb begin
    w_haz_nxt = r_haz ^ w_haz_rise;
    w_lt_nxt  = 1'b0;
    w_rt_nxt  = 1'b0;
    if ((w_state_nxt == c_PRESS || w_state_nxt == c_COMFORT ||
         w_state_nxt == c_HOLD) && !w_haz_nxt) begin
      w_lt_nxt = (w_dir_nxt == c_DIR_L);
      w_rt_nxt = (w_dir_nxt == c_DIR_R);
    end
  end

  assign lt  = r_lt;
  assign rt  = r_rt;
  assign haz = r_haz;

endmodule
`default_nettype wire

// File: tb/tb_turn_signal_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_turn_signal_ctrl
//  Purpose  : Directed self-checking bench for turn_signal_ctrl with
//             hand-computed cycle timings (DB_CYCLES=4, TAP_MAX=16,
//             SWEEP_CYCLES=4, TAP_FLASHES=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_turn_signal_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic stalk_l, stalk_r, haz_btn, cancel;
  logic lt, rt, haz;

  int n_total = 0;
  int n_bad   = 0;

  turn_signal_ctrl #(
    .DB_CYCLES   (4),
    .TAP_MAX     (16),
    .SWEEP_CYCLES(4),
    .TAP_FLASHES (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .stalk_l(stalk_l),
    .stalk_r(stalk_r),
    .haz_btn(haz_btn),
    .cancel (cancel),
    .lt     (lt),
    .rt     (rt),
    .haz    (haz)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 ns past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Safety net: the directed sequence is bounded, but never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic flag;

  initial begin
    rst_n   = 1'b0;
    stalk_l = 1'b0;
    stalk_r = 1'b0;
    haz_btn = 1'b0;
    cancel  = 1'b0;

    // ---------------- 1. reset with toggling inputs, then a short glitch
    for (int i = 0; i < 6; i++) begin
      step(1);
      stalk_l = i[0];
      stalk_r = ~i[0];
      haz_btn = i[1];
      cancel  = i[0];
    end
    check("rst_lt", lt, 0);
    check("rst_rt", rt, 0);
    check("rst_haz", haz, 0);
    stalk_l = 0; stalk_r = 0; haz_btn = 0; cancel = 0;
    step(3);
    rst_n = 1'b1;
    step(5);
    stalk_l = 1'b1;
    step(3);
    stalk_l = 1'b0;
    step(12);
    check("glitch_lt", lt, 0);
    check("glitch_haz", haz, 0);

    // ---------------- 2. comfort tap: 10-cycle press
    stalk_l = 1'b1;              // raw rise after edge 0
    step(6);
    check("tap_lt_e6", lt, 0);
    step(1);
    check("tap_lt_e7", lt, 1);
    step(3);
    stalk_l = 1'b0;              // raw fall after edge 10 (F)
    step(7);                     // F+7: COMFORT entry
    check("tap_lt_comfort", lt, 1);
    check("tap_rt_comfort", rt, 0);
    step(11);                    // F+18
    check("tap_lt_f18", lt, 1);
    step(1);                     // F+19 = COMFORT entry + 12
    check("tap_lt_f19", lt, 0);
    check("tap_rt_end", rt, 0);
    step(5);

    // ---------------- 3. hold and release on the right
    stalk_r = 1'b1;
    step(7);
    check("hold_rt_e7", rt, 1);
    flag = 1'b1;
    for (int i = 0; i < 33; i++) begin
      step(1);
      if (rt !== 1'b1 || lt !== 1'b0) flag = 1'b0;
    end
    check("hold_rt_cont", flag, 1);
    stalk_r = 1'b0;              // raw fall after edge 40
    step(6);
    check("hold_rt_f6", rt, 1);
    step(1);
    check("hold_rt_f7", rt, 0);  // comfort would have kept it on
    step(5);

    // ---------------- 4. cancel and re-arm
    stalk_l = 1'b1;
    step(30);                    // HOLD reached at edge 23
    check("cxl_lt_hold", lt, 1);
    cancel = 1'b1;
    step(1);
    cancel = 1'b0;
    check("cxl_lt_next", lt, 0);
    step(10);
    check("cxl_lt_waitrel", lt, 0);
    stalk_l = 1'b0;
    step(10);
    check("cxl_lt_released", lt, 0);
    stalk_l = 1'b1;
    step(7);
    check("cxl_lt_rearm", lt, 1);
    stalk_l = 1'b0;
    step(25);
    check("cxl_lt_idle", lt, 0);

    // ---------------- 5. hazard priority
    stalk_l = 1'b1;
    step(30);
    check("haz_lt_hold", lt, 1);
    haz_btn = 1'b1;
    step(6);
    check("haz_haz_e6", haz, 0);
    check("haz_lt_e6", lt, 1);
    step(1);
    check("haz_haz_e7", haz, 1);
    check("haz_lt_e7", lt, 0);
    step(1);
    haz_btn = 1'b0;
    step(10);
    check("haz_haz_held", haz, 1);
    check("haz_lt_masked", lt, 0);
    haz_btn = 1'b1;
    step(7);
    check("haz_haz_off", haz, 0);
    check("haz_lt_back", lt, 1);
    step(1);
    haz_btn = 1'b0;
    stalk_l = 1'b0;
    step(20);
    check("haz_lt_idle", lt, 0);

    // ---------------- 6a. stalk fault during PRESS(L)
    stalk_l = 1'b1;
    step(7);
    check("flt_lt_press", lt, 1);
    stalk_r = 1'b1;
    step(6);
    check("flt_lt_e6", lt, 1);
    step(1);
    check("flt_lt_idle", lt, 0);
    check("flt_rt_idle", rt, 0);
    stalk_l = 1'b0;
    stalk_r = 1'b0;
    step(15);
    check("flt_lt_after", lt, 0);
    check("flt_rt_after", rt, 0);

    // ---------------- 6b. direction change from COMFORT(L)
    stalk_l = 1'b1;
    step(8);
    stalk_l = 1'b0;              // fall after edge 8, COMFORT at edge 15
    step(8);                     // edge 16
    stalk_r = 1'b1;
    step(6);                     // edge 22
    check("dir_lt_e22", lt, 1);
    check("dir_rt_e22", rt, 0);
    step(1);                     // edge 23
    check("dir_lt_e23", lt, 0);
    check("dir_rt_e23", rt, 1);
    stalk_r = 1'b0;
    step(30);

    // ---------------- 7. asynchronous reset mid-HOLD
    stalk_l = 1'b1;
    step(30);
    check("arst_lt_hold", lt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_lt_async", lt, 0);
    stalk_l = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(10);
    check("arst_lt_after", lt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
